// File: rtl/pe_core_gen2.sv
// pe_core_gen2: systolic PE with double-buffered WS weights, OS drain FSM,
// pipelined signed/unsigned multiply and optional saturating accumulation.
module pe_core_gen2 #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int MUL_LAT    = 1,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_flow,
    input  logic                  signed_mode,
    input  logic                  load,
    input  logic                  swap,
    input  logic                  drain,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] left,
    input  logic                  left_valid,
    input  logic [ACC_WIDTH-1:0]  up,
    input  logic                  up_valid,
    output logic [DATA_WIDTH-1:0] right,
    output logic                  right_valid,
    output logic [ACC_WIDTH-1:0]  down,
    output logic                  down_valid,
    output logic                  sat_flag
);
    typedef enum logic [1:0] {ACC, DUMP, PASS} state_e;
    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   right_q, w_act_q, w_act_d, w_sh_q, w_sh_d, op_b;
    logic                    right_valid_q, down_valid_q, down_valid_d, sat_q, sat_d, drain_q;
    logic [ACC_WIDTH-1:0]    down_q, down_d, acc_q, acc_d, prod;
    logic [ACC_WIDTH-1:0]    pipe_q [MUL_LAT];
    logic [MUL_LAT-1:0]      pv_q;
    logic                    pv;
    logic signed [DATA_WIDTH:0]     a_x, b_x;
    logic signed [2*DATA_WIDTH+1:0] prod_full;
    logic [ACC_WIDTH:0]      ws_sum, acc_sum;

    // Top bit of the result is the overflow indication.
    function automatic logic [ACC_WIDTH:0] add_sat(input logic [ACC_WIDTH-1:0] a, input logic [ACC_WIDTH-1:0] b, input logic sgn);
        logic [ACC_WIDTH:0] s;
        logic               ovf;
        logic [ACC_WIDTH-1:0] clamp;
        s     = sgn ? {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b} : {1'b0, a} + {1'b0, b};
        ovf   = sgn ? s[ACC_WIDTH] ^ s[ACC_WIDTH-1] : s[ACC_WIDTH];
        clamp = !sgn ? '1 : s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return {ovf, (SATURATE != 0 && ovf) ? clamp : s[ACC_WIDTH-1:0]};
    endfunction

    assign op_b      = data_flow ? w_act_q : up[DATA_WIDTH-1:0];
    assign a_x       = {signed_mode & left[DATA_WIDTH-1], left};
    assign b_x       = {signed_mode & op_b[DATA_WIDTH-1], op_b};
    assign prod_full = a_x * b_x;
    assign pv        = pv_q[MUL_LAT-1];
    assign prod      = pv ? pipe_q[MUL_LAT-1] : '0;
    assign ws_sum    = add_sat(up_valid ? up : '0, prod, signed_mode);
    assign acc_sum   = add_sat(acc_q, prod, signed_mode);

    // Widening cast of the signed product gives sign- or zero-extension as needed.
    always_ff @(posedge clk) begin
        pipe_q[0] <= ACC_WIDTH'(prod_full);
        for (int i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        down_d       = down_q;
        down_valid_d = down_valid_q;
        sat_d        = sat_q;
        w_act_d      = w_act_q;
        w_sh_d       = w_sh_q;
        if (clr) begin
            state_d = ACC;
            acc_d   = '0;
            sat_d   = 1'b0;
        end else if (data_flow) begin
            state_d      = ACC;
            w_sh_d       = load ? up[DATA_WIDTH-1:0] : w_sh_q;
            w_act_d      = swap ? w_sh_q : w_act_q;
            down_d       = load ? up : ws_sum[ACC_WIDTH-1:0];
            down_valid_d = load ? up_valid : (pv | up_valid);
            sat_d        = sat_q | (!load & ws_sum[ACC_WIDTH]);
        end else begin
            case (state_q)
                ACC: begin
                    down_d       = up;
                    down_valid_d = up_valid;
                    acc_d        = acc_sum[ACC_WIDTH-1:0];
                    sat_d        = sat_q | acc_sum[ACC_WIDTH];
                    state_d      = (drain && !drain_q) ? DUMP : ACC;
                end
                DUMP: begin
                    down_d       = acc_sum[ACC_WIDTH-1:0];
                    down_valid_d = 1'b1;
                    sat_d        = sat_q | acc_sum[ACC_WIDTH];
                    state_d      = drain ? PASS : ACC;
                    acc_d        = drain ? acc_q : '0;
                end
                PASS: begin
                    down_d       = up;
                    down_valid_d = up_valid;
                    state_d      = drain ? PASS : ACC;
                    acc_d        = drain ? acc_q : '0;
                end
                default: state_d = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ACC;
            acc_q         <= '0;
            down_q        <= '0;
            down_valid_q  <= 1'b0;
            sat_q         <= 1'b0;
            w_act_q       <= '0;
            w_sh_q        <= '0;
            right_q       <= '0;
            right_valid_q <= 1'b0;
            drain_q       <= 1'b0;
            pv_q          <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            down_q        <= down_d;
            down_valid_q  <= down_valid_d;
            sat_q         <= sat_d;
            w_act_q       <= w_act_d;
            w_sh_q        <= w_sh_d;
            right_q       <= left;
            right_valid_q <= left_valid;
            drain_q       <= drain;
            pv_q[0]       <= !clr & left_valid & (data_flow | up_valid);
            for (int i = 1; i < MUL_LAT; i++) pv_q[i] <= !clr & pv_q[i-1];
        end
    end

    assign right       = right_q;
    assign right_valid = right_valid_q;
    assign down        = down_q;
    assign down_valid  = down_valid_q;
    assign sat_flag    = sat_q;
endmodule

// File: tb/tb_pe_core_gen2.sv
// tb_pe_core_gen2: directed stimulus, per-cycle behavioural model of the 24-bit
// PE plus literal checks on two 16-bit saturating/wrapping instances.
module tb_pe_core_gen2;
    localparam int DW = 8;
    localparam int AW = 24;
    localparam int ML = 2;

    logic          clk = 1'b0;
    logic          rst_n, data_flow, signed_mode, load, swap, drain, clr, left_valid, up_valid;
    logic [DW-1:0] left;
    logic [AW-1:0] up;
    logic [15:0]   up16;
    logic [DW-1:0] right_m, right_s1, right_s0;
    logic          rv_m, rv_s1, rv_s0, dv_m, dv_s1, dv_s0, sat_m, sat_s1, sat_s0;
    logic [AW-1:0] down_m;
    logic [15:0]   down_s1, down_s0;
    int            n_chk = 0;
    int            n_fail = 0;

    assign up16 = up[15:0];
    always #5 clk = ~clk;

    pe_core_gen2 #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MUL_LAT(ML), .SATURATE(1)) u_main (
        .clk(clk), .rst_n(rst_n), .data_flow(data_flow), .signed_mode(signed_mode), .load(load),
        .swap(swap), .drain(drain), .clr(clr), .left(left), .left_valid(left_valid), .up(up),
        .up_valid(up_valid), .right(right_m), .right_valid(rv_m), .down(down_m), .down_valid(dv_m),
        .sat_flag(sat_m));
    pe_core_gen2 #(.DATA_WIDTH(DW), .ACC_WIDTH(16), .MUL_LAT(ML), .SATURATE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .data_flow(data_flow), .signed_mode(signed_mode), .load(load),
        .swap(swap), .drain(drain), .clr(clr), .left(left), .left_valid(left_valid), .up(up16),
        .up_valid(up_valid), .right(right_s1), .right_valid(rv_s1), .down(down_s1), .down_valid(dv_s1),
        .sat_flag(sat_s1));
    pe_core_gen2 #(.DATA_WIDTH(DW), .ACC_WIDTH(16), .MUL_LAT(ML), .SATURATE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .data_flow(data_flow), .signed_mode(signed_mode), .load(load),
        .swap(swap), .drain(drain), .clr(clr), .left(left), .left_valid(left_valid), .up(up16),
        .up_valid(up_valid), .right(right_s0), .right_valid(rv_s0), .down(down_s0), .down_valid(dv_s0),
        .sat_flag(sat_s0));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of u_main: mathematical values, products delayed through a queue.
    logic [DW-1:0] m_right, m_wa, m_ws;
    logic          m_rv, m_dv, m_sat, prev_drain;
    longint        m_down, m_acc;
    int            phase;
    longint        pq[$];
    bit            pvq[$];

    function automatic longint sv24(input logic [AW-1:0] v, input logic s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction
    function automatic longint sv8(input logic [DW-1:0] v, input logic s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction

    task automatic pq_reset();
        pq.delete();
        pvq.delete();
        repeat (ML) begin
            pq.push_back(0);
            pvq.push_back(1'b0);
        end
    endtask

    task automatic madd(input longint a, input longint b, output longint r);
        longint s, lo, hi;
        s  = a + b;
        lo = signed_mode ? -(longint'(1) << (AW-1)) : 0;
        hi = signed_mode ? (longint'(1) << (AW-1)) - 1 : (longint'(1) << AW) - 1;
        if (s > hi || s < lo) m_sat = 1'b1;
        r = s > hi ? hi : s < lo ? lo : s;
    endtask

    task automatic model_step();
        longint pval, hv, r;
        bit hp;
        logic [DW-1:0] b, old_sh;
        if (!rst_n) begin
            m_right = '0; m_rv = 0; m_down = 0; m_dv = 0; m_sat = 0;
            m_wa = '0; m_ws = '0; m_acc = 0; phase = 0; prev_drain = 0;
            pq_reset();
            return;
        end
        m_right = left;
        m_rv    = left_valid;
        if (clr) begin
            m_acc = 0; m_sat = 0; phase = 0; prev_drain = drain;
            pq_reset();
            return;
        end
        hp   = pvq.pop_front();
        hv   = pq.pop_front();
        pval = hp ? hv : 0;
        b    = data_flow ? m_wa : up[DW-1:0];
        pq.push_back(sv8(left, signed_mode) * sv8(b, signed_mode));
        pvq.push_back(left_valid & (data_flow | up_valid));
        if (data_flow) begin
            old_sh = m_ws;
            if (load) begin
                m_ws = up[DW-1:0]; m_down = longint'(up); m_dv = up_valid;
            end else begin
                madd(up_valid ? sv24(up, signed_mode) : 0, pval, r);
                m_down = r; m_dv = hp | up_valid;
            end
            if (swap) m_wa = old_sh;
            phase = 0;
        end else if (phase == 0) begin
            m_down = longint'(up); m_dv = up_valid;
            if (hp) begin
                madd(sv24(m_acc[AW-1:0], signed_mode), pval, r);
                m_acc = r;
            end
            if (drain && !prev_drain) phase = 1;
        end else if (phase == 1) begin
            madd(sv24(m_acc[AW-1:0], signed_mode), pval, r);
            m_down = r; m_dv = 1'b1;
            if (drain) phase = 2;
            else begin phase = 0; m_acc = 0; end
        end else begin
            m_down = longint'(up); m_dv = up_valid;
            if (!drain) begin phase = 0; m_acc = 0; end
        end
        prev_drain = drain;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        #1;
        check("right", right_m, m_right);
        check("right_valid", rv_m, m_rv);
        check("down", down_m, m_down[AW-1:0]);
        check("down_valid", dv_m, m_dv);
        check("sat_flag", sat_m, m_sat);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // Literal expectation on the main DUT's down, also pinning the model.
    task automatic lit_down(input string name, input logic [AW-1:0] exp, input logic exp_v);
        check({name, " down"}, down_m, exp);
        check({name, " down_valid"}, dv_m, exp_v);
        check({name, " model"}, m_down[AW-1:0], exp);
    endtask

    initial begin
        rst_n = 0; data_flow = 1; signed_mode = 1; load = 0; swap = 0; drain = 0; clr = 0;
        left = '0; left_valid = 0; up = '0; up_valid = 0;
        repeat (2) cyc();
        check("reset right", right_m, 0);
        check("reset right_valid", rv_m, 0);
        check("reset down", down_m, 0);
        check("reset down_valid", dv_m, 0);
        check("reset sat", sat_m, 0);
        check("reset s1 right_valid", rv_s1, 0);
        check("reset s0 right", right_s0, 0);
        rst_n = 1;
        // WS basic: weight 5, 3*5 + 100
        load = 1; up = 5; cyc();
        load = 0; swap = 1; up = 0; cyc();
        swap = 0; left = 3; left_valid = 1; cyc();
        check("t1 right", right_m, 3);
        check("t1 right_valid", rv_m, 1);
        left = 0; left_valid = 0; cyc();
        up = 100; up_valid = 1; cyc();
        lit_down("t1", 24'd115, 1);
        up = 0; up_valid = 0;
        // Double buffer
        load = 1; up = 24'hFFFFF9; left = 2; left_valid = 1; cyc();
        lit_down("t2 pass", 24'hFFFFF9, 0);
        load = 0; up = 0; left = 0; left_valid = 0; cyc(); cyc();
        lit_down("t2 old weight", 24'd10, 1);
        swap = 1; cyc();
        swap = 0; left = 2; left_valid = 1; cyc();
        left_valid = 0; cyc(); cyc();
        lit_down("t2 new weight", 24'hFFFFF2, 1);
        load = 1; swap = 1; up = 9; up_valid = 1; cyc();
        lit_down("t2 load+swap pass", 24'd9, 1);
        load = 0; swap = 0; up = 0; up_valid = 0;
        left = 1; left_valid = 1; cyc();
        left_valid = 0; cyc(); cyc();
        lit_down("t2 active=-7", 24'hFFFFF9, 1);
        swap = 1; cyc();
        swap = 0; left = 1; left_valid = 1; cyc();
        left_valid = 0; cyc(); cyc();
        lit_down("t2 active=9", 24'd9, 1);
        // Signedness
        load = 1; up = 24'hFF; cyc();
        load = 0; up = 0; swap = 1; cyc();
        swap = 0; signed_mode = 0; left = 8'hFF; left_valid = 1; cyc();
        left_valid = 0; cyc(); cyc();
        lit_down("t5 unsigned", 24'd65025, 1);
        signed_mode = 1; left_valid = 1; cyc();
        left_valid = 0; cyc(); cyc();
        lit_down("t5 signed", 24'd1, 1);
        // Saturation on 16-bit instances
        clr = 1; cyc();
        clr = 0;
        check("t4 s1 sat cleared", sat_s1, 0);
        check("t4 s0 sat cleared", sat_s0, 0);
        load = 1; up = 127; cyc();
        load = 0; swap = 1; up = 0; cyc();
        swap = 0; left = 127; left_valid = 1; cyc();
        left_valid = 0; cyc();
        up = 32700; up_valid = 1; cyc();
        up = 0; up_valid = 0;
        check("t4 s1 down", down_s1, 16'h7FFF);
        check("t4 s1 sat", sat_s1, 1);
        check("t4 s0 down", down_s0, 16'hBEBD);
        check("t4 s0 sat", sat_s0, 1);
        lit_down("t4 main", 24'd48829, 1);
        check("t4 main sat", sat_m, 0);
        cyc();
        check("t4 s1 sticky", sat_s1, 1);
        check("t4 s0 sticky", sat_s0, 1);
        clr = 1; cyc();
        clr = 0;
        check("t4 s1 clr", sat_s1, 0);
        check("t4 s0 clr", sat_s0, 0);
        // OS accumulate and drain
        data_flow = 0;
        for (int i = 1; i <= 4; i++) begin
            left = DW'(i); up = AW'(i + 4); left_valid = 1; up_valid = 1; cyc();
        end
        left_valid = 0; up_valid = 0; up = 0; cyc();
        drain = 1; up = 1234; up_valid = 1; cyc();
        cyc();
        lit_down("t3 dump", 24'd70, 1);
        cyc();
        lit_down("t3 pass", 24'd1234, 1);
        drain = 0; up = 0; up_valid = 0; cyc();
        left = 1; up = 1; left_valid = 1; up_valid = 1; cyc();
        left_valid = 0; up_valid = 0; up = 0; cyc();
        drain = 1; cyc();
        drain = 0; cyc();
        lit_down("t3 acc cleared", 24'd1, 1);
        // Reset during PASS
        left = 5; up = 5; left_valid = 1; up_valid = 1; cyc();
        left_valid = 0; up_valid = 0; up = 0; cyc();
        drain = 1; cyc(); cyc();
        lit_down("t6 dump", 24'd25, 1);
        up = 777; up_valid = 1; left = 7; left_valid = 1; cyc();
        lit_down("t6 pass", 24'd777, 1);
        rst_n = 0;
        #1;
        check("t6 async right", right_m, 0);
        check("t6 async right_valid", rv_m, 0);
        check("t6 async down", down_m, 0);
        check("t6 async down_valid", dv_m, 0);
        check("t6 async sat", sat_m, 0);
        check("t6 async s1 down", down_s1, 0);
        drain = 0; left = 0; left_valid = 0; up = 0; up_valid = 0;
        cyc(); cyc();
        rst_n = 1; cyc();
        drain = 1; cyc();
        drain = 0; cyc();
        lit_down("t6 post-reset drain", 24'd0, 1);
        check("t6 right_valid idle", rv_m, 0);
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
